// File: rtl/divider_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : divider_fsm
//  Purpose  : 4-bit by 2-bit unsigned restoring divider. Produces one
//             quotient bit per clock, MSB first, and takes 4 RUN cycles per
//             request. A zero divisor skips RUN entirely and reports
//             quotient=4'b1111, remainder=0 with dbz set.
//  Ports    : clk        - clock, rising edge active
//             rst_n      - asynchronous active-low reset
//             start      - request a division (honoured in IDLE or DONE)
//             dividend   - 4-bit unsigned dividend, latched on accept
//             divisor    - 2-bit unsigned divisor, latched on accept
//             busy       - high while in RUN
//             done       - one-cycle pulse in DONE, results valid
//             quotient   - 4-bit quotient (holds last result)
//             remainder  - 2-bit remainder (holds last result)
//             dbz        - divide-by-zero flag of the last accepted request
//  Revision : 1.0 - initial release
// ============================================================================
module divider_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [1:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [1:0] remainder,
    output logic       dbz
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [1:0] r_cnt;
    logic [3:0] r_q;       // dividend shifts out of the top, quotient in at the bottom
    logic [1:0] r_rem;
    logic [1:0] r_div;
    logic       r_dbz;

    logic       w_accept;
    logic [2:0] w_t;
    logic       w_ge;
    logic [1:0] w_diff;

    // A request is only taken when not mid-division; start in RUN is dropped.
    assign w_accept = start && ((r_state == C_IDLE) || (r_state == C_DONE));

    // Partial remainder with the next dividend bit shifted in.
    assign w_t  = {r_rem, r_q[3]};
    assign w_ge = (w_t >= {1'b0, r_div});
    // Only the low two bits matter: when t >= d the true difference is < d <= 3.
    assign w_diff = w_t[1:0] - r_div;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_IDLE, C_DONE: begin
                if (start) begin
                    w_next_state = (divisor == 2'd0) ? C_DONE : C_RUN;
                end else begin
                    w_next_state = C_IDLE;
                end
            end
            C_RUN: begin
                if (r_cnt == 2'd3) begin
                    w_next_state = C_DONE;
                end
            end
            default: w_next_state = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operand latch on accept, one restoring step per RUN cycle
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
            r_q   <= 4'd0;
            r_rem <= 2'd0;
            r_div <= 2'd0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= 2'd0;
            r_rem <= 2'd0;
            r_div <= divisor;
            if (divisor == 2'd0) begin
                r_q   <= 4'b1111;
                r_dbz <= 1'b1;
            end else begin
                r_q   <= dividend;
                r_dbz <= 1'b0;
            end
        end else if (r_state == C_RUN) begin
            r_cnt <= r_cnt + 2'd1;
            if (w_ge) begin
                r_rem <= w_diff;
                r_q   <= {r_q[2:0], 1'b1};
            end else begin
                r_rem <= w_t[1:0];
                r_q   <= {r_q[2:0], 1'b0};
            end
        end
    end

    assign busy      = (r_state == C_RUN);
    assign done      = (r_state == C_DONE);
    assign quotient  = r_q;
    assign remainder = r_rem;
    assign dbz       = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_divider_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divider_fsm
//  Purpose  : Directed self-checking bench for divider_fsm.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_divider_fsm;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [1:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [1:0] remainder;
    logic       dbz;

    int vectors;
    int miscompares;
    int done_pulses;
    int en;
    int ed;

    divider_fsm u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_pulses <= done_pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one single-cycle request and check the whole transaction.
    task automatic run_op(input logic [3:0] n, input logic [1:0] d,
                          input logic [3:0] eq, input logic [1:0] er, input logic edbz);
        dividend = n;
        divisor  = d;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = ~n;
        divisor  = ~d;
        if (d != 2'd0) begin
            for (int c = 0; c < 4; c++) begin
                chk("busy_in_run", 8'(busy), 8'd1);
                chk("done_in_run", 8'(done), 8'd0);
                tick();
            end
        end else begin
            chk("busy_dbz", 8'(busy), 8'd0);
        end
        chk("done_pulse", 8'(done), 8'd1);
        chk("busy_done", 8'(busy), 8'd0);
        chk("quotient", 8'(quotient), 8'(eq));
        chk("remainder", 8'(remainder), 8'(er));
        chk("dbz", 8'(dbz), 8'(edbz));
        tick();
        chk("done_low_idle", 8'(done), 8'd0);
        chk("busy_low_idle", 8'(busy), 8'd0);
        chk("quotient_hold", 8'(quotient), 8'(eq));
        chk("remainder_hold", 8'(remainder), 8'(er));
        chk("dbz_hold", 8'(dbz), 8'(edbz));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        done_pulses = 0;
        en          = 0;
        ed          = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        dividend    = 4'd0;
        divisor     = 2'd0;

        // Reset state
        #12;
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_quotient", 8'(quotient), 8'd0);
        chk("rst_remainder", 8'(remainder), 8'd0);
        chk("rst_dbz", 8'(dbz), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic divisions
        run_op(4'd13, 2'd3, 4'd4, 2'd1, 1'b0);
        run_op(4'd15, 2'd1, 4'd15, 2'd0, 1'b0);
        run_op(4'd0, 2'd2, 4'd0, 2'd0, 1'b0);

        // Divide by zero
        run_op(4'd6, 2'd0, 4'b1111, 2'd0, 1'b1);

        // Start during RUN is ignored: 9/2 with 3/3 pulsed in the 2nd busy cycle
        dividend = 4'd9;
        divisor  = 2'd2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("ign_busy1", 8'(busy), 8'd1);
        tick();
        chk("ign_busy2", 8'(busy), 8'd1);
        dividend = 4'd3;
        divisor  = 2'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("ign_busy3", 8'(busy), 8'd1);
        tick();
        chk("ign_busy4", 8'(busy), 8'd1);
        tick();
        chk("ign_done", 8'(done), 8'd1);
        chk("ign_quotient", 8'(quotient), 8'd4);
        chk("ign_remainder", 8'(remainder), 8'd1);
        chk("ign_dbz", 8'(dbz), 8'd0);
        tick();
        chk("ign_no_requeue_busy", 8'(busy), 8'd0);
        chk("ign_no_requeue_done", 8'(done), 8'd0);
        tick();
        chk("ign_idle_busy", 8'(busy), 8'd0);

        // Reset during the 3rd busy cycle aborts the division
        dividend = 4'd13;
        divisor  = 2'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        chk("abort_busy3", 8'(busy), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_done", 8'(done), 8'd0);
        chk("abort_quotient", 8'(quotient), 8'd0);
        chk("abort_remainder", 8'(remainder), 8'd0);
        chk("abort_dbz", 8'(dbz), 8'd0);
        tick();
        tick();
        chk("abort_no_done", 8'(done), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd10, 2'd3, 4'd3, 2'd1, 1'b0);

        // Back-to-back sweep with start held high, n=0..15, d=1..3
        dividend = 4'd0;
        divisor  = 2'd1;
        start    = 1'b1;
        tick();
        for (int i = 0; i < 48; i++) begin
            en = i / 3;
            ed = (i % 3) + 1;
            if (i < 47) begin
                dividend = 4'((i + 1) / 3);
                divisor  = 2'(((i + 1) % 3) + 1);
            end else begin
                start = 1'b0;
            end
            for (int c = 0; c < 4; c++) begin
                chk("sweep_busy", 8'(busy), 8'd1);
                tick();
            end
            chk("sweep_done", 8'(done), 8'd1);
            chk("sweep_quotient", 8'(quotient), 8'(en / ed));
            chk("sweep_remainder", 8'(remainder), 8'(en % ed));
            chk("sweep_identity", 8'(int'(quotient) * ed + int'(remainder)), 8'(en));
            chk("sweep_rem_lt_div", (int'(remainder) < ed) ? 8'd1 : 8'd0, 8'd1);
            tick();
        end
        chk("sweep_end_busy", 8'(busy), 8'd0);
        chk("sweep_end_done", 8'(done), 8'd0);

        // 6 directed requests completed plus 48 sweep requests; aborted one gives none
        tick();
        chk("done_pulse_count", 8'(done_pulses), 8'd54);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divider_fsm.md
DIVIDER_FSM -- requirements
Module: divider_fsm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to begin a division; sampled on rising clk.
REQ-005 dividend  input  4  unsigned dividend n, the 4-bit product format f3..f0.
REQ-006 divisor  input  2  unsigned divisor d, the 2-bit operand format {c,d}.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse when results become valid.
REQ-009 quotient  output  4  unsigned quotient q.
REQ-010 remainder  output  2  unsigned remainder r.
REQ-011 dbz  output  1  divide-by-zero flag for the last accepted request.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 In IDLE or DONE, start=1 at a rising edge SHALL accept the request and latch dividend and divisor into internal registers.
REQ-014 Inputs dividend and divisor SHALL be ignored at all edges other than the accepting edge.
REQ-015 Accepted with divisor!=0: next state SHALL be RUN, the step counter SHALL be cleared, and dbz SHALL be cleared.
REQ-016 Accepted with divisor==0: next state SHALL be DONE, with quotient=4'b1111, remainder=2'b00, and dbz=1; no RUN cycles occur.
REQ-017 RUN SHALL perform restoring division, one quotient bit per cycle, MSB first, for exactly 4 cycles.
REQ-018 Each RUN step SHALL compute the 3-bit value t={r[1:0], q_shift[3]} and shift q_shift left by one.
REQ-019 In each RUN step, if t>=divisor then r=t-divisor and q_shift[0]=1; otherwise r=t[1:0] and q_shift[0]=0. Because r<d<=3, r SHALL be stored in 2 bits.
REQ-020 After the 4th RUN step the FSM SHALL enter DONE; quotient and remainder SHALL then satisfy n = q*d + r with r < d.
REQ-021 busy SHALL be 1 exactly in RUN, i.e. for 4 consecutive cycles per nonzero-divisor request.
REQ-022 done SHALL be 1 exactly in DONE, i.e. for one cycle.
REQ-023 In DONE without start, the next state SHALL be IDLE.
REQ-024 In DONE with start, the next state SHALL follow REQ-015/016 (back-to-back operation).
REQ-025 start while in RUN SHALL be ignored and SHALL NOT be queued.
REQ-026 quotient, remainder and dbz SHALL hold their last results through IDLE until the next DONE. During RUN they MAY show intermediate values and SHALL NOT be relied upon.
REQ-027 Latency from the accepting edge to the done-high cycle SHALL be 5 edges for divisor!=0 and 1 edge for divisor==0.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, busy=0, done=0, quotient=0, remainder=0, dbz=0, counter=0, and clear the operand registers.
REQ-029 Reset asserted in RUN SHALL abort the division with no done pulse.
REQ-030 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where rst_n=1.

Verification
REQ-031 n=13, d=3, start 1 cycle -> busy high 4 cycles, then done 1 cycle; q=4, r=1, dbz=0.
REQ-032 n=15, d=1 -> q=15, r=0. Then n=0, d=2 -> q=0, r=0.
REQ-033 n=6, d=0 -> done on the next cycle with busy never high; q=4'b1111, r=0, dbz=1.
REQ-034 n=9, d=2 started; start pulsed with n=3, d=3 during the 2nd busy cycle -> ignored; q=4, r=1, single done pulse.
REQ-035 rst_n low in the 3rd busy cycle -> all outputs 0 asynchronously, no done. After release, n=10, d=3 -> q=3, r=1.
REQ-036 Exhaustive sweep n=0..15, d=1..3, with start held high continuously (back-to-back from DONE) -> every result satisfies n=q*d+r, r<d; one done per request; no idle cycle between requests.
